// File: rtl/mc_alu_issue_ctrl_pkg.sv
// Shared widths, operation codes and record types for the multi-cycle ALU issue controller.
// Optional build macro used by the top level: MC_ISSUE_WB_BYPASS_EN.
package mc_alu_issue_ctrl_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int REG_IDX_WIDTH = 5;
  localparam int NUM_REGS      = 2 ** REG_IDX_WIDTH;
  localparam int ALU_LATENCY   = 4;
  localparam int OP_WIDTH      = 6;

  localparam logic [OP_WIDTH-1:0] OP_NOP  = 6'h00;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 6'h01;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 6'h02;
  localparam logic [OP_WIDTH-1:0] OP_AND  = 6'h03;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 6'h04;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 6'h05;
  localparam logic [OP_WIDTH-1:0] OP_IMUL = 6'h06;

  typedef struct packed {
    logic                     valid;
    logic [REG_IDX_WIDTH-1:0] dest;
  } tag_t;

  typedef struct packed {
    logic [REG_IDX_WIDTH-1:0] dest;
    logic [DATA_WIDTH-1:0]    result;
  } res_entry_t;

endpackage

// File: rtl/mc_alu_issue_ctrl_if.sv
// Issue, ALU and writeback signals of the issue controller.
// Handshakes: a transfer happens in a cycle where valid & ready are both high; valid never depends on ready.
interface mc_alu_issue_ctrl_if;
  import mc_alu_issue_ctrl_pkg::*;

  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [OP_WIDTH-1:0]      issue_op_i;
  logic [REG_IDX_WIDTH-1:0] issue_dest_i;
  logic                     issue_src1_valid_i;
  logic                     issue_src2_valid_i;
  logic [REG_IDX_WIDTH-1:0] issue_src1_i;
  logic [REG_IDX_WIDTH-1:0] issue_src2_i;
  logic [DATA_WIDTH-1:0]    issue_operand1_i;
  logic [DATA_WIDTH-1:0]    issue_operand2_i;
  logic [OP_WIDTH-1:0]      alu_operation_o;
  logic [DATA_WIDTH-1:0]    alu_operand1_o;
  logic [DATA_WIDTH-1:0]    alu_operand2_o;
  logic [DATA_WIDTH-1:0]    alu_result_i;
  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [REG_IDX_WIDTH-1:0] wb_dest_o;
  logic [DATA_WIDTH-1:0]    wb_result_o;
  logic                     idle_o;

  modport slave (
    input  issue_valid_i, issue_op_i, issue_dest_i,
           issue_src1_valid_i, issue_src2_valid_i, issue_src1_i, issue_src2_i,
           issue_operand1_i, issue_operand2_i, alu_result_i, wb_ready_i,
    output issue_ready_o, alu_operation_o, alu_operand1_o, alu_operand2_o,
           wb_valid_o, wb_dest_o, wb_result_o, idle_o
  );

  modport master (
    output issue_valid_i, issue_op_i, issue_dest_i,
           issue_src1_valid_i, issue_src2_valid_i, issue_src1_i, issue_src2_i,
           issue_operand1_i, issue_operand2_i, alu_result_i, wb_ready_i,
    input  issue_ready_o, alu_operation_o, alu_operand1_o, alu_operand2_o,
           wb_valid_o, wb_dest_o, wb_result_o, idle_o
  );
endinterface

// File: rtl/mc_result_fifo.sv
// Synchronous in-order FIFO with occupancy count; simultaneous push and pop leave the count unchanged.
module mc_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= push_data;
  end

  // Issue credit reserves a slot for every op in flight, so a full FIFO never sees a push.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && full));
  end
endmodule

// File: rtl/mc_alu_issue_ctrl.sv
// Issue/writeback controller for the fixed-latency ALU: scoreboard, tag pipeline, result FIFO, credit.
// Build option MC_ISSUE_WB_BYPASS_EN lets a same-cycle writeback clear a hazard.
module mc_alu_issue_ctrl
  import mc_alu_issue_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  mc_alu_issue_ctrl_if.slave bus
);
  localparam int NSTG = ALU_LATENCY - 1;
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int SW   = $clog2(NSTG + FIFO_DEPTH + 1) + 1;

  tag_t                stage_q [NSTG];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] eff_pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                ready;
  logic                fire;
  logic                hazard;
  logic                credit;
  logic                push;
  logic                wb_valid;
  logic                wb_fire;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [SW-1:0]       inflight;
  res_entry_t          push_entry;
  res_entry_t          head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NSTG; i++) inflight = inflight + SW'(stage_q[i].valid);
  end

  // A pop this cycle is deliberately not counted: credit comes only from registered occupancy.
  assign credit = (inflight + SW'(fifo_count)) < SW'(FIFO_DEPTH);

`ifdef MC_ISSUE_WB_BYPASS_EN
  assign eff_pending = pending_q & ~clr_mask;
`else
  assign eff_pending = pending_q;
`endif

  assign hazard = (bus.issue_src1_valid_i & eff_pending[bus.issue_src1_i])
                | (bus.issue_src2_valid_i & eff_pending[bus.issue_src2_i])
                | eff_pending[bus.issue_dest_i];

  assign ready             = !reset & !hazard & credit;
  assign fire              = bus.issue_valid_i & ready;
  assign bus.issue_ready_o = ready;

  assign bus.alu_operation_o = fire ? bus.issue_op_i : OP_NOP;
  assign bus.alu_operand1_o  = bus.issue_operand1_i;
  assign bus.alu_operand2_o  = bus.issue_operand2_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTG; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= '{valid: fire, dest: bus.issue_dest_i};
      for (int i = 1; i < NSTG; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  // The last tag stage lines up with the cycle the ALU result is on alu_result_i.
  assign push       = stage_q[NSTG-1].valid;
  assign push_entry = '{dest: stage_q[NSTG-1].dest, result: bus.alu_result_i};

  mc_result_fifo #(
    .WIDTH ($bits(res_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (wb_fire),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wb_valid        = !fifo_empty & !reset;
  assign wb_fire         = wb_valid & bus.wb_ready_i;
  assign bus.wb_valid_o  = wb_valid;
  assign bus.wb_dest_o   = head.dest;
  assign bus.wb_result_o = head.result;
  assign bus.idle_o      = (inflight == '0) & fifo_empty;

  assign set_mask = fire    ? (NUM_REGS'(1) << bus.issue_dest_i) : '0;
  assign clr_mask = wb_fire ? (NUM_REGS'(1) << head.dest)        : '0;

  // Set after clear: a new op to the register being written back keeps it pending.
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= (pending_q & ~clr_mask) | set_mask;
  end
endmodule

// File: tb/tb_mc_alu_issue_ctrl.sv
// Directed bench for mc_alu_issue_ctrl with a behavioural 4-cycle ALU and hand-computed writebacks.
module tb_mc_alu_issue_ctrl;
  import mc_alu_issue_ctrl_pkg::*;

`ifdef MC_ISSUE_WB_BYPASS_EN
  localparam int HZ_FIRE = 4;
`else
  localparam int HZ_FIRE = 5;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_alu_issue_ctrl_if bus ();

  mc_alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural ALU: result of the op presented in cycle N appears in cycle N+3.
  logic [DATA_WIDTH-1:0] alu_p [ALU_LATENCY-1];

  function automatic logic [DATA_WIDTH-1:0] alu_fn(input logic [OP_WIDTH-1:0] op,
                                                   input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_IMUL: return DATA_WIDTH'(a * b);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_p[0] <= alu_fn(bus.alu_operation_o, bus.alu_operand1_o, bus.alu_operand2_o);
    for (int i = 1; i < ALU_LATENCY - 1; i++) alu_p[i] <= alu_p[i-1];
  end

  assign bus.alu_result_i = alu_p[ALU_LATENCY-2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic exp_v,
                          input logic [REG_IDX_WIDTH-1:0] exp_d, input logic [31:0] exp_r);
    check({tag, "_wbv"}, 32'(bus.wb_valid_o), 32'(exp_v));
    if (exp_v) begin
      check({tag, "_wbd"}, 32'(bus.wb_dest_o), 32'(exp_d));
      check({tag, "_wbr"}, bus.wb_result_o, exp_r);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_op(input logic [OP_WIDTH-1:0] op, input logic [REG_IDX_WIDTH-1:0] dest,
                          input logic s1v, input logic [REG_IDX_WIDTH-1:0] s1,
                          input logic [31:0] a, input logic [31:0] b);
    bus.issue_valid_i      = 1'b1;
    bus.issue_op_i         = op;
    bus.issue_dest_i       = dest;
    bus.issue_src1_valid_i = s1v;
    bus.issue_src1_i       = s1;
    bus.issue_src2_valid_i = 1'b0;
    bus.issue_src2_i       = '0;
    bus.issue_operand1_i   = a;
    bus.issue_operand2_i   = b;
  endtask

  task automatic drive_idle();
    bus.issue_valid_i      = 1'b0;
    bus.issue_op_i         = OP_ADD;
    bus.issue_dest_i       = '0;
    bus.issue_src1_valid_i = 1'b0;
    bus.issue_src1_i       = '0;
    bus.issue_src2_valid_i = 1'b0;
    bus.issue_src2_i       = '0;
    bus.issue_operand1_i   = '0;
    bus.issue_operand2_i   = '0;
  endtask

  // First op fires in cycle 0; the second is held valid and must stall until cycle HZ_FIRE.
  task automatic hz_case(input string tag,
                         input logic [OP_WIDTH-1:0] op1, input logic [REG_IDX_WIDTH-1:0] d1,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e1,
                         input logic [OP_WIDTH-1:0] op2, input logic [REG_IDX_WIDTH-1:0] d2,
                         input logic s1v, input logic [REG_IDX_WIDTH-1:0] s1,
                         input logic [31:0] a2, input logic [31:0] b2, input logic [31:0] e2);
    next_cyc(); drive_op(op1, d1, 1'b0, '0, a1, b1); settle();
    check({tag, "_rdy0"}, 32'(bus.issue_ready_o), 32'd1);
    for (int k = 1; k <= HZ_FIRE; k++) begin
      next_cyc(); drive_op(op2, d2, s1v, s1, a2, b2); settle();
      check($sformatf("%s_rdy%0d", tag, k), 32'(bus.issue_ready_o), 32'(k == HZ_FIRE));
      check_wb($sformatf("%s_c%0d", tag, k), k == 4, d1, e1);
    end
    check({tag, "_op2"}, 32'(bus.alu_operation_o), 32'(op2));
    for (int k = HZ_FIRE + 1; k <= HZ_FIRE + 3; k++) begin
      next_cyc(); drive_idle(); settle();
      check_wb($sformatf("%s_c%0d", tag, k), 1'b0, '0, '0);
    end
    next_cyc(); settle();
    check_wb({tag, "_second"}, 1'b1, d2, e2);
    next_cyc(); settle();
    check({tag, "_idle"}, 32'(bus.idle_o), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.wb_ready_i = 1'b1;
    drive_op(OP_ADD, 5'd1, 1'b0, '0, 32'd1, 32'd1);

    // Reset: offered op must not fire
    repeat (2) next_cyc();
    settle();
    check("rst_rdy", 32'(bus.issue_ready_o), 32'd0);
    check("rst_wbv", 32'(bus.wb_valid_o), 32'd0);
    check("rst_op", 32'(bus.alu_operation_o), 32'(OP_NOP));
    next_cyc(); reset = 1'b0; drive_idle(); settle();
    check("rst_idle", 32'(bus.idle_o), 32'd1);

    // IMUL dest 3: 6*7 = 42 written back in cycle 4
    next_cyc(); drive_op(OP_IMUL, 5'd3, 1'b0, '0, 32'd6, 32'd7); settle();
    check("mul_rdy", 32'(bus.issue_ready_o), 32'd1);
    check("mul_op", 32'(bus.alu_operation_o), 32'(OP_IMUL));
    next_cyc(); drive_idle(); settle();
    check("nofire_op", 32'(bus.alu_operation_o), 32'(OP_NOP));
    check("mul_busy", 32'(bus.idle_o), 32'd0);
    for (int k = 2; k <= 3; k++) begin
      next_cyc(); settle();
      check_wb($sformatf("mul_c%0d", k), 1'b0, '0, '0);
    end
    next_cyc(); settle();
    check_wb("mul_c4", 1'b1, 5'd3, 32'd42);
    // Cycle 5: r3 no longer pending, a reader of r3 issues at once (10+5 = 15)
    next_cyc(); drive_op(OP_ADD, 5'd4, 1'b1, 5'd3, 32'd10, 32'd5); settle();
    check_wb("mul_c5", 1'b0, '0, '0);
    check("mul_idle5", 32'(bus.idle_o), 32'd1);
    check("mul_pend3", 32'(bus.issue_ready_o), 32'd1);
    next_cyc(); drive_idle();
    repeat (2) next_cyc();
    next_cyc(); settle();
    check_wb("add_c9", 1'b1, 5'd4, 32'd15);
    next_cyc();

    // RAW: ADD r5 = 1+2, then SUB r6 = 9-4 reading r5
    hz_case("raw", OP_ADD, 5'd5, 32'd1, 32'd2, 32'd3,
            OP_SUB, 5'd6, 1'b1, 5'd5, 32'd9, 32'd4, 32'd5);
    // WAW: XOR r2 = F0^0F, then OR r2 = 30|03, in order
    hz_case("waw", OP_XOR, 5'd2, 32'hF0, 32'h0F, 32'hFF,
            OP_OR, 5'd2, 1'b0, '0, 32'h30, 32'h03, 32'h33);

    // Backpressure: four independent ops fill every credit
    bus.wb_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cyc(); drive_op(OP_ADD, 5'(8 + k), 1'b0, '0, 32'(k + 1), 32'd100); settle();
      check($sformatf("bp_rdy%0d", k), 32'(bus.issue_ready_o), 32'd1);
    end
    for (int k = 4; k <= 10; k++) begin
      next_cyc();
      if (k == 10) bus.wb_ready_i = 1'b1;
      drive_op(OP_ADD, 5'd12, 1'b0, '0, 32'd7, 32'd8); settle();
      check($sformatf("bp_stall%0d", k), 32'(bus.issue_ready_o), 32'd0);
      check($sformatf("bp_op%0d", k), 32'(bus.alu_operation_o), 32'(OP_NOP));
      check_wb($sformatf("bp_c%0d", k), 1'b1, 5'd8, 32'd101);
    end
    next_cyc(); settle();
    check("bp_rdy11", 32'(bus.issue_ready_o), 32'd1);
    check_wb("bp_c11", 1'b1, 5'd9, 32'd102);
    next_cyc(); drive_idle(); settle();
    check_wb("bp_c12", 1'b1, 5'd10, 32'd103);
    next_cyc(); settle();
    check_wb("bp_c13", 1'b1, 5'd11, 32'd104);
    next_cyc(); settle();
    check_wb("bp_c14", 1'b0, '0, '0);
    next_cyc(); settle();
    check_wb("bp_c15", 1'b1, 5'd12, 32'd15);
    next_cyc(); settle();
    check("bp_idle", 32'(bus.idle_o), 32'd1);

    // Mid-flight reset: AND r13 fired cycle 0 is dropped
    next_cyc(); drive_op(OP_AND, 5'd13, 1'b0, '0, 32'hFF, 32'h0F); settle();
    check("mr_rdy0", 32'(bus.issue_ready_o), 32'd1);
    next_cyc(); drive_idle();
    next_cyc(); reset = 1'b1; drive_op(OP_ADD, 5'd14, 1'b0, '0, 32'd1, 32'd1); settle();
    check("mr_rdy2", 32'(bus.issue_ready_o), 32'd0);
    check("mr_op2", 32'(bus.alu_operation_o), 32'(OP_NOP));
    next_cyc(); reset = 1'b0; drive_op(OP_ADD, 5'd13, 1'b0, '0, 32'd2, 32'd3); settle();
    check("mr_idle3", 32'(bus.idle_o), 32'd1);
    check("mr_rdy3", 32'(bus.issue_ready_o), 32'd1);
    for (int k = 4; k <= 6; k++) begin
      next_cyc(); drive_idle(); settle();
      check_wb($sformatf("mr_c%0d", k), 1'b0, '0, '0);
    end
    next_cyc(); settle();
    check_wb("mr_c7", 1'b1, 5'd13, 32'd5);
    next_cyc(); settle();
    check_wb("mr_c8", 1'b0, '0, '0);
    check("mr_idle8", 32'(bus.idle_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_alu_issue_ctrl.md
Name: mc_alu_issue_ctrl

Overview:
- Initiator and writeback side for the fixed-latency multi-cycle scalar ALU.
- Accepts scalar instructions with register tags and runs a register scoreboard for RAW/WAW hazards.
- Drives the ALU's operation and operand inputs, then tracks tags through the ALU's 4-cycle pipeline.
- Captures the unregistered ALU result into a result FIFO that feeds a valid/ready register-file writeback port. Prevents result loss under writeback backpressure using credit-based issue.

Parameters:
DATA_WIDTH, 32, operand/result width
REG_IDX_WIDTH, 5, register index width
NUM_REGS, 32, scoreboard entries (2**REG_IDX_WIDTH)
ALU_LATENCY, 4, cycles from issue to ALU result (result visible combinationally in cycle N+ALU_LATENCY-1)
FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
issue_valid_i  in  1  instruction offered
issue_ready_o  out  1  instruction accepted when valid&ready
issue_op_i  in  6  operation code
issue_dest_i  in  REG_IDX_WIDTH  destination register
issue_src1_valid_i / issue_src2_valid_i  in  1 each  source is a register read
issue_src1_i / issue_src2_i  in  REG_IDX_WIDTH each  source registers
issue_operand1_i / issue_operand2_i  in  DATA_WIDTH each  operand values
alu_operation_o  out  6  to ALU operation input
alu_operand1_o / alu_operand2_o  out  DATA_WIDTH each  to ALU operands
alu_result_i  in  DATA_WIDTH  ALU result (unregistered)
wb_valid_o  out  1  writeback available
wb_ready_i  in  1  register file accepts
wb_dest_o  out  REG_IDX_WIDTH  writeback register
wb_result_o  out  DATA_WIDTH  writeback value
idle_o  out  1  no ops in flight, FIFO empty

Behaviour:
- Fire = issue_valid_i & issue_ready_o.
- alu_operation_o = issue_op_i when fire, else OP_NOP (6'h00). Operands pass through combinationally and unconditionally.
- Tag pipeline: ALU_LATENCY-1 registered stages of {valid, dest}.
  - Stage 1 loads {fire, issue_dest_i}.
  - When the last stage is valid, alu_result_i and that stage's dest are pushed into the FIFO at the end of the cycle.
  - An op fired in cycle N has its result on alu_result_i in cycle N+3. It reaches wb_valid_o no earlier than cycle N+4.
- Scoreboard: pending[NUM_REGS].
  - Set pending[dest] on fire.
  - Clear pending[wb_dest_o] on wb_valid_o & wb_ready_i.
  - Set and clear of the same register in one cycle cannot occur without the bypass, because the dest hazard stalls the issue.
  - Register 0 is not special.
- issue_ready_o = !reset & !hazard & credit.
  - hazard = (src1_valid & pending[src1]) | (src2_valid & pending[src2]) | pending[dest].
  - credit = (inflight_count + fifo_count) < FIFO_DEPTH. A pop in the same cycle does not add credit.
- FIFO:
  - In-order; wb_valid_o = !empty; head drives wb_dest_o/wb_result_o.
  - Push to a full FIFO is impossible by construction; assertion in simulation.
  - Simultaneous push and pop keeps the count unchanged.
- idle_o = no valid tag stage & FIFO empty.
- Reset (any cycle, including mid-operation):
  - Clears tag valids, FIFO pointers/count and all pending bits.
  - Ops already inside the ALU are discarded; their results are never pushed.
  - During reset: wb_valid_o=0, issue_ready_o=0, alu_operation_o=OP_NOP.
  - idle_o=1 from the first cycle after reset.

Optional Feature:
MC_ISSUE_WB_BYPASS_EN
- Defined: a register whose pending bit is being cleared by a writeback firing this cycle is treated as not pending for the hazard check. The dependent op may issue in the same cycle as the writeback. If that op's dest equals the cleared register, set wins and pending stays 1.
- Undefined: hazard uses registered pending only; the dependent issue follows one cycle after the writeback.

Decomposition:
- Shared package:
  - OP_NOP and the existing operation code constants
  - REG_IDX_WIDTH
  - ALU_LATENCY
  - the tag typedef {valid, dest}
  - the result FIFO entry typedef {dest, result}
- One sub-module: mc_result_fifo, a parameterised synchronous FIFO with count output and synchronous active-high reset.

Test Plan:
- IMUL, dest 3, operands 6 and 7, fired cycle 0, wb_ready_i=1 -> wb_valid_o=1 in cycle 4 with dest 3, result 42. pending[3]=0 from cycle 5. idle_o=1 in cycle 5.
- RAW: op dest 5 fired cycle 0, then op with src1=5 held valid -> issue_ready_o=0 cycles 1–4 and fires cycle 5. With MC_ISSUE_WB_BYPASS_EN it fires cycle 4.
- WAW: two ops back-to-back both dest 2 -> second stalls until the first writeback completes. Writebacks appear in order with the correct values.
- Backpressure: wb_ready_i=0, four independent ops fired cycles 0–3 -> fifth stalls. Raise wb_ready_i in cycle 10 -> results drain one per cycle in issue order, and the fifth op fires cycle 11.
- Reset: op fired cycle 0, reset high in cycle 2 -> no writeback ever appears for it. All pending bits clear and idle_o=1 from cycle 3. A new op issued in cycle 3 writes back in cycle 7.
- No-fire cycles: issue_valid_i=0 or stalled -> alu_operation_o=6'h00, and no FIFO push 3 cycles later.
